weighted_round_robin: RTL
=========================

WEIGHTED_ROUND_ROBIN -- requirements
Module: weighted_round_robin

Interface
REQ-001 SHALL have parameter REQUEST_WIDTH, default 8, number of requesters (>=2).
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 4, width of each per-requester weight.
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_weight  input  REQUEST_WIDTH x WEIGHT_WIDTH (packed, [REQUEST_WIDTH-1:0][WEIGHT_WIDTH-1:0])  maximum consecutive grant cycles per requester.
REQ-006 SHALL have port i_request  input  REQUEST_WIDTH  request per requester; bit i belongs to requester i.
REQ-007 SHALL have port o_grant  output  REQUEST_WIDTH  grant vector; one-hot or all-zero.

Function
REQ-008 SHALL hold internal state: owner index, owner_valid flag, credit counter (WEIGHT_WIDTH bits), priority pointer (log2 REQUEST_WIDTH bits).
REQ-009 SHALL drive o_grant combinationally from i_request and internal state; grant is valid in the same cycle as the request.
REQ-010 SHALL keep o_grant a subset of i_request at all times; o_grant = 0 whenever i_request = 0.
REQ-011 SHALL treat effective weight as i_weight[i], except weight 0, which is treated as 1.
REQ-012 SHALL select the winner as the owner when owner_valid=1 and i_request[owner]=1 (continuation).
REQ-013 SHALL otherwise select the winner as the first set i_request bit found by a circular search starting at pointer: pointer, pointer+1, ..., wrapping from REQUEST_WIDTH-1 to 0 (new acquisition).
REQ-014 SHALL, on a new acquisition of winner w, update owner<=w, pointer<=(w+1) mod REQUEST_WIDTH, credit<=effective_weight(w)-1, owner_valid<=(effective_weight(w)>1).
REQ-015 SHALL, on a continuation cycle, update credit<=credit-1 and owner_valid<=(credit>1); pointer is unchanged.
REQ-016 SHALL sample i_weight only at acquisition; weight changes during an ownership period do not affect it.
REQ-017 SHALL, when the owner deasserts its request while owner_valid=1, re-arbitrate in the same cycle per REQ-013 with no idle bubble; the remaining credit is discarded.
REQ-018 SHALL, in a cycle with i_request=0, set owner_valid<=0 and leave pointer and credit unchanged.
REQ-019 SHALL, when the owner's credit expires, place that requester last in circular order for the next acquisition, guaranteed by REQ-014.
REQ-020 SHALL guarantee that a continuously asserted request is granted within sum of all other effective weights + 1 cycles.
REQ-021 SHALL never make a continuation grant to a requester whose i_request bit is 0.

Reset
REQ-022 SHALL, on i_rst_n=0, immediately and asynchronously set pointer=0, owner=0, owner_valid=0, credit=0.
REQ-023 SHALL make o_grant equal the first set bit of i_request searched from bit 0 while reset is asserted (o_grant=0 if i_request=0).
REQ-024 SHALL, on reset asserted mid-burst, abandon the burst; after release, arbitration restarts from requester 0.

Verification
REQ-025 Reset then i_request=8'hFF, all weights 1 -> o_grant 01,02,04,08,10,20,40,80,01 on consecutive cycles.
REQ-026 i_weight[0]=3, others 1, i_request=8'hFF held -> o_grant 01,01,01,02,04,...,80,01,01,01.
REQ-027 i_weight[2]=4, i_request=8'h24 from the first cycle with pointer=0 -> o_grant 04,04; bit 2 dropped in cycle 3 -> o_grant=20 in that same cycle; then 20 for its weight.
REQ-028 All weights 0, i_request=8'h81 held -> o_grant alternates 01,80,01,80 (weight 0 behaves as 1).
REQ-029 i_weight[1]=5, i_request=8'h02, i_rst_n pulsed low during the third grant cycle -> state cleared; after release with i_request=8'h03 -> o_grant=01 first.
REQ-030 Random requests, random weights, 10k cycles -> o_grant always one-hot or zero and a subset of i_request; consecutive grants to one requester never exceed its effective weight unless it is the only requester; REQ-020 starvation bound never violated.

Source files
------------

// File: rtl/weighted_round_robin.sv
// Weighted round-robin arbiter.
// A requester that wins a new acquisition keeps the grant for up to its
// weight in consecutive cycles (weight 0 counts as 1), as long as it keeps
// requesting. When its credit runs out, or it drops its request, the grant
// moves to the next requester in circular order after it. The grant is
// combinational, so a request can be granted in the cycle it is raised.
module weighted_round_robin #(
    parameter int REQUEST_WIDTH = 8,
    parameter int WEIGHT_WIDTH  = 4
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst_n,
    input  logic [REQUEST_WIDTH-1:0][WEIGHT_WIDTH-1:0] i_weight,
    input  logic [REQUEST_WIDTH-1:0]                   i_request,
    output logic [REQUEST_WIDTH-1:0]                   o_grant
);

    localparam int PTR_W = $clog2(REQUEST_WIDTH);

    logic [PTR_W-1:0]        owner;
    logic [PTR_W-1:0]        pointer;
    logic                    owner_valid;
    logic [WEIGHT_WIDTH-1:0] credit;

    logic [PTR_W-1:0]        search_idx;
    logic                    search_found;
    logic [PTR_W-1:0]        winner;
    logic [PTR_W-1:0]        next_pointer;
    logic [WEIGHT_WIDTH-1:0] win_weight;
    logic                    continuation;
    logic                    any_req;

    // Circular search for the first active request starting at the pointer.
    always_comb begin
        int idx;
        idx          = 0;
        search_found = 1'b0;
        search_idx   = '0;
        for (int k = 0; k < REQUEST_WIDTH; k++) begin
            idx = int'(pointer) + k;
            if (idx >= REQUEST_WIDTH) begin
                idx = idx - REQUEST_WIDTH;
            end
            if (!search_found && i_request[PTR_W'(idx)]) begin
                search_found = 1'b1;
                search_idx   = PTR_W'(idx);
            end
        end
    end

    // Winner selection: the current owner keeps the grant while it still
    // requests and holds credit; otherwise the circular search decides.
    always_comb begin
        any_req      = |i_request;
        continuation = owner_valid && i_request[owner];
        winner       = continuation ? owner : search_idx;
        win_weight   = i_weight[winner];
        if (winner == PTR_W'(REQUEST_WIDTH - 1)) begin
            next_pointer = '0;
        end else begin
            next_pointer = winner + PTR_W'(1);
        end
    end

    // One-hot grant for the winner, all-zero when nobody requests.
    always_comb begin
        o_grant = '0;
        if (any_req) begin
            o_grant[winner] = 1'b1;
        end
    end

    // Ownership, credit and pointer bookkeeping; weight is sampled only at
    // acquisition, so later weight changes do not stretch a running burst.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            owner       <= '0;
            pointer     <= '0;
            owner_valid <= 1'b0;
            credit      <= '0;
        end else if (!any_req) begin
            owner_valid <= 1'b0;
        end else if (continuation) begin
            credit      <= credit - WEIGHT_WIDTH'(1);
            owner_valid <= (credit > WEIGHT_WIDTH'(1));
        end else begin
            owner   <= search_idx;
            pointer <= next_pointer;
            if (win_weight == '0) begin
                credit      <= '0;
                owner_valid <= 1'b0;
            end else begin
                credit      <= win_weight - WEIGHT_WIDTH'(1);
                owner_valid <= (win_weight > WEIGHT_WIDTH'(1));
            end
        end
    end

endmodule
